lemming_tracker: RTL and testbench

- Downstream monitor for the Lemmings walker FSM.
- Consumes the FSM's per-cycle status outputs (walk_left, walk_right, aaah, digging) and tracks horizontal position, dig/fall depth and fall duration.
- Detects a splat (landing after too long a fall) and enters a sticky dead state.
- Flags protocol violations on its inputs.
- Feeds scoring/display logic and the bench scoreboards.

---
 rtl/lemming_tracker_pkg.sv | 16 +
 rtl/sat_counter.sv | 33 +++
 rtl/lemming_tracker.sv | 136 +++++++++++++
 tb/tb_lemming_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lemming_tracker_pkg.sv
// Shared types and default constants for the lemming_tracker monitor.
// Optional build macro LEMMING_TRACKER_XWRAP_EN (see lemming_tracker.sv).
package lemming_tracker_pkg;

  // Tracker state: on the ground, mid-fall, or splatted.
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR    = 2'd1,
    DEAD   = 2'd2
  } state_t;

  localparam int X_INIT_DEF     = 128;
  localparam int X_MAX_DEF      = 255;
  localparam int FALL_LIMIT_DEF = 20;

endpackage

// File: rtl/sat_counter.sv
// Up/down counter with a configurable ceiling, optional wrap-around and a
// synchronous load. Used for horizontal position, depth and fall duration.
module sat_counter #(
  parameter int           W       = 8,
  parameter logic [W-1:0] MAX     = '1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter bit           WRAP    = 1'b0
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // Load has priority over inc, inc over dec; ends either clamp or wrap.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      if (q >= MAX) q <= WRAP ? '0 : MAX;
      else          q <= q + 1'b1;
    end else if (dec) begin
      if (q == '0) q <= WRAP ? MAX : '0;
      else         q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/lemming_tracker.sv
// Downstream monitor for the Lemmings walker FSM: tracks x position,
// descended depth and fall duration, detects fatal landings and flags
// illegal (not exactly one-hot) status inputs.
// Build macro LEMMING_TRACKER_XWRAP_EN: x_pos wraps modulo X_MAX+1 instead
// of saturating at 0 / X_MAX.
// Input protocol: the four status inputs are sampled every rising edge and
// exactly one of them must be high; any other pattern sets proto_err and
// leaves all tracking state untouched for that cycle. There is no
// backpressure: every output is a registered view of the previous sample.
module lemming_tracker
  import lemming_tracker_pkg::*;
#(
  parameter int XW         = 8,
  parameter int X_INIT     = X_INIT_DEF,
  parameter int X_MAX      = X_MAX_DEF,
  parameter int DW         = 8,
  parameter int FCW        = 5,
  parameter int FALL_LIMIT = FALL_LIMIT_DEF
) (
  input  logic           clk,
  input  logic           areset,
  input  logic           walk_left,
  input  logic           walk_right,
  input  logic           aaah,
  input  logic           digging,
  output logic [XW-1:0]  x_pos,
  output logic [DW-1:0]  depth,
  output logic [FCW-1:0] fall_cnt,
  output logic           splat,
  output logic           dead,
  output logic           proto_err,
  output state_t         state_dbg
);

`ifdef LEMMING_TRACKER_XWRAP_EN
  localparam bit X_WRAP = 1'b1;
`else
  localparam bit X_WRAP = 1'b0;
`endif

  state_t         state, next_state;
  logic [3:0]     in_vec;
  logic           legal;
  logic           x_inc, x_dec;
  logic           d_inc;
  logic           fc_inc, fc_load;
  logic [FCW-1:0] fc_load_val;
  logic           splat_d;
  logic           err_d;

  assign in_vec = {walk_left, walk_right, aaah, digging};
  // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
  assign legal  = (in_vec != 4'd0) && ((in_vec & (in_vec - 4'd1)) == 4'd0);

  // State, splat pulse and sticky protocol error registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= GROUND;
      splat     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= next_state;
      splat     <= splat_d;
      proto_err <= err_d;
    end
  end

  // Next-state and counter control decode from the current sample.
  always_comb begin
    next_state  = state;
    x_inc       = 1'b0;
    x_dec       = 1'b0;
    d_inc       = 1'b0;
    fc_inc      = 1'b0;
    fc_load     = 1'b0;
    fc_load_val = '0;
    splat_d     = 1'b0;
    err_d       = proto_err;
    if (state != DEAD && !legal) begin
      err_d = 1'b1;
    end else begin
      case (state)
        GROUND: begin
          if (walk_left)  x_dec = 1'b1;
          if (walk_right) x_inc = 1'b1;
          if (digging)    d_inc = 1'b1;
          if (aaah) begin
            next_state  = AIR;
            fc_load     = 1'b1;
            fc_load_val = FCW'(1);
            d_inc       = 1'b1;
          end
        end
        AIR: begin
          if (aaah) begin
            fc_inc = 1'b1;
            d_inc  = 1'b1;
          end else if (fall_cnt > FCW'(FALL_LIMIT)) begin
            // Fatal landing: fall_cnt keeps its final value for inspection.
            next_state = DEAD;
            splat_d    = 1'b1;
          end else begin
            next_state = GROUND;
            fc_load    = 1'b1;
          end
        end
        default: ;  // DEAD: everything frozen until areset
      endcase
    end
  end

  sat_counter #(
    .W(XW), .MAX(XW'(X_MAX)), .RST_VAL(XW'(X_INIT)), .WRAP(X_WRAP)
  ) u_x (
    .clk(clk), .areset(areset), .inc(x_inc), .dec(x_dec),
    .load(1'b0), .load_val('0), .q(x_pos)
  );

  sat_counter #(
    .W(DW), .MAX('1), .RST_VAL('0), .WRAP(1'b0)
  ) u_depth (
    .clk(clk), .areset(areset), .inc(d_inc), .dec(1'b0),
    .load(1'b0), .load_val('0), .q(depth)
  );

  sat_counter #(
    .W(FCW), .MAX('1), .RST_VAL('0), .WRAP(1'b0)
  ) u_fall (
    .clk(clk), .areset(areset), .inc(fc_inc), .dec(1'b0),
    .load(fc_load), .load_val(fc_load_val), .q(fall_cnt)
  );

  assign dead      = (state == DEAD);
  assign state_dbg = state;

endmodule

// File: tb/tb_lemming_tracker.sv
// Directed self-checking bench for lemming_tracker.
module tb_lemming_tracker;
  import lemming_tracker_pkg::*;

  logic       clk;
  logic       areset;
  logic       walk_left, walk_right, aaah, digging;
  logic [7:0] x_pos;
  logic [7:0] depth;
  logic [4:0] fall_cnt;
  logic       splat, dead, proto_err;
  state_t     state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  lemming_tracker dut (
    .clk(clk), .areset(areset),
    .walk_left(walk_left), .walk_right(walk_right),
    .aaah(aaah), .digging(digging),
    .x_pos(x_pos), .depth(depth), .fall_cnt(fall_cnt),
    .splat(splat), .dead(dead), .proto_err(proto_err),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: inputs change 1ns after a rising edge, outputs read there too.
  task automatic step(input logic l, input logic r, input logic a, input logic d);
    walk_left = l; walk_right = r; aaah = a; digging = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    walk_left = 0; walk_right = 0; aaah = 0; digging = 0;
    areset = 1'b1;
    @(posedge clk);
    #3;
    areset = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (x_pos !== 8'd128) begin tests_failed++; $display("FAIL reset_x got %0d exp 128", x_pos); end
    tests_run++;
    if (depth !== 8'd0 || fall_cnt !== 5'd0) begin tests_failed++; $display("FAIL reset_depth_fc got %0d/%0d exp 0/0", depth, fall_cnt); end
    tests_run++;
    if (dead !== 1'b0 || splat !== 1'b0 || proto_err !== 1'b0 || state_dbg !== GROUND) begin
      tests_failed++; $display("FAIL reset_flags got dead=%b splat=%b err=%b st=%0d exp 0 0 0 0", dead, splat, proto_err, state_dbg);
    end
  endtask

  task automatic test_walk_right();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 0);
      tests_run++;
      if (x_pos !== 8'(128 + i)) begin tests_failed++; $display("FAIL walk_right_%0d got %0d exp %0d", i, x_pos, 128 + i); end
    end
  endtask

  task automatic test_x_edges();
    logic [7:0] exp_l [3];
`ifdef LEMMING_TRACKER_XWRAP_EN
    exp_l[0] = 8'd255; exp_l[1] = 8'd254; exp_l[2] = 8'd253;
`else
    exp_l[0] = 8'd0; exp_l[1] = 8'd0; exp_l[2] = 8'd0;
`endif
    do_reset();
    for (int i = 0; i < 128; i++) step(1, 0, 0, 0);
    tests_run++;
    if (x_pos !== 8'd0) begin tests_failed++; $display("FAIL walk_to_zero got %0d exp 0", x_pos); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      tests_run++;
      if (x_pos !== exp_l[i]) begin tests_failed++; $display("FAIL left_edge_%0d got %0d exp %0d", i, x_pos, exp_l[i]); end
    end
    // Walk right up to X_MAX, then one more step past it.
    while (x_pos != 8'd255) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    tests_run++;
`ifdef LEMMING_TRACKER_XWRAP_EN
    if (x_pos !== 8'd0) begin tests_failed++; $display("FAIL right_edge got %0d exp 0", x_pos); end
`else
    if (x_pos !== 8'd255) begin tests_failed++; $display("FAIL right_edge got %0d exp 255", x_pos); end
`endif
  endtask

  task automatic test_fall_survive();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 1, 0);
      tests_run++;
      if (fall_cnt !== 5'(i) || depth !== 8'(i) || state_dbg !== AIR) begin
        tests_failed++; $display("FAIL fall20_%0d got fc=%0d depth=%0d st=%0d exp %0d %0d AIR", i, fall_cnt, depth, state_dbg, i, i);
      end
    end
    step(1, 0, 0, 0);
    tests_run++;
    if (fall_cnt !== 5'd0 || dead !== 1'b0 || splat !== 1'b0 || state_dbg !== GROUND) begin
      tests_failed++; $display("FAIL land20 got fc=%0d dead=%b splat=%b st=%0d exp 0 0 0 GROUND", fall_cnt, dead, splat, state_dbg);
    end
    tests_run++;
    if (depth !== 8'd20 || x_pos !== 8'd128) begin tests_failed++; $display("FAIL land20_pos got depth=%0d x=%0d exp 20 128", depth, x_pos); end
    step(1, 0, 0, 0);
    tests_run++;
    if (x_pos !== 8'd127) begin tests_failed++; $display("FAIL after_land_walk got %0d exp 127", x_pos); end
  endtask

  task automatic test_fall_splat();
    do_reset();
    for (int i = 0; i < 21; i++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    tests_run++;
    if (splat !== 1'b1 || dead !== 1'b1 || fall_cnt !== 5'd21) begin
      tests_failed++; $display("FAIL splat21 got splat=%b dead=%b fc=%0d exp 1 1 21", splat, dead, fall_cnt);
    end
    tests_run++;
    if (x_pos !== 8'd128 || depth !== 8'd21) begin tests_failed++; $display("FAIL splat21_pos got x=%0d depth=%0d exp 128 21", x_pos, depth); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      tests_run++;
      if (splat !== 1'b0 || dead !== 1'b1 || x_pos !== 8'd128 || depth !== 8'd21 || fall_cnt !== 5'd21) begin
        tests_failed++; $display("FAIL dead_frozen_%0d got splat=%b dead=%b x=%0d depth=%0d fc=%0d exp 0 1 128 21 21", i, splat, dead, x_pos, depth, fall_cnt);
      end
    end
    step(1, 0, 0, 1);
    tests_run++;
    if (proto_err !== 1'b0 || dead !== 1'b1) begin tests_failed++; $display("FAIL dead_ignores_illegal got err=%b dead=%b exp 0 1", proto_err, dead); end
  endtask

  task automatic test_proto();
    do_reset();
    step(1, 0, 0, 1);
    tests_run++;
    if (proto_err !== 1'b1 || x_pos !== 8'd128 || depth !== 8'd0) begin
      tests_failed++; $display("FAIL illegal_two got err=%b x=%0d depth=%0d exp 1 128 0", proto_err, x_pos, depth);
    end
    step(0, 0, 0, 0);
    tests_run++;
    if (proto_err !== 1'b1 || x_pos !== 8'd128 || depth !== 8'd0) begin
      tests_failed++; $display("FAIL illegal_zero got err=%b x=%0d depth=%0d exp 1 128 0", proto_err, x_pos, depth);
    end
    step(0, 1, 0, 0);
    tests_run++;
    if (proto_err !== 1'b1 || x_pos !== 8'd129) begin tests_failed++; $display("FAIL resume_walk got err=%b x=%0d exp 1 129", proto_err, x_pos); end
    step(0, 0, 0, 1);
    tests_run++;
    if (depth !== 8'd1) begin tests_failed++; $display("FAIL resume_dig got %0d exp 1", depth); end
    // Illegal cycle mid-fall must hold fall_cnt and state.
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    tests_run++;
    if (fall_cnt !== 5'd1 || depth !== 8'd2 || state_dbg !== AIR) begin
      tests_failed++; $display("FAIL illegal_air got fc=%0d depth=%0d st=%0d exp 1 2 AIR", fall_cnt, depth, state_dbg);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    tests_run++;
    if (fall_cnt !== 5'd7) begin tests_failed++; $display("FAIL pre_reset_fc got %0d exp 7", fall_cnt); end
    #2;
    areset = 1'b1;
    #1;
    tests_run++;
    if (fall_cnt !== 5'd0 || depth !== 8'd0 || x_pos !== 8'd128 || state_dbg !== GROUND) begin
      tests_failed++; $display("FAIL async_reset got fc=%0d depth=%0d x=%0d st=%0d exp 0 0 128 GROUND", fall_cnt, depth, x_pos, state_dbg);
    end
    #1;
    areset = 1'b0;
    step(0, 0, 1, 0);
    tests_run++;
    if (fall_cnt !== 5'd1 || depth !== 8'd1) begin tests_failed++; $display("FAIL post_reset_fall got fc=%0d depth=%0d exp 1 1", fall_cnt, depth); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) step(0, 0, 0, 1);
    tests_run++;
    if (depth !== 8'd255) begin tests_failed++; $display("FAIL depth_sat got %0d exp 255", depth); end
    do_reset();
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0);
    tests_run++;
    if (fall_cnt !== 5'd31 || depth !== 8'd40) begin tests_failed++; $display("FAIL fc_sat got fc=%0d depth=%0d exp 31 40", fall_cnt, depth); end
    step(0, 0, 0, 1);
    tests_run++;
    if (dead !== 1'b1 || splat !== 1'b1 || fall_cnt !== 5'd31) begin
      tests_failed++; $display("FAIL fc_sat_land got dead=%b splat=%b fc=%0d exp 1 1 31", dead, splat, fall_cnt);
    end
  endtask

  initial begin
    areset = 1'b1;
    walk_left = 0; walk_right = 0; aaah = 0; digging = 0;
    test_reset();
    test_walk_right();
    test_x_edges();
    test_fall_survive();
    test_fall_splat();
    test_proto();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
